bridge_cmd_issuer: RTL and testbench
====================================

BRIDGE_CMD_ISSUER -- requirements
Module: bridge_cmd_issuer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bus data width.
REQ-002 SHALL have parameter BB_ADDR_WIDTH, default 12, bridge address width.
REQ-003 SHALL have parameter CLOCKS_PER_PULSE, default 5208, clk cycles per UART bit.
REQ-004 SHALL have parameter RESP_TIMEOUT, default 65535, max cycles waiting for a read response.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, command offered.
- req_ready, output, 1, command accepted when high with req_valid.
- req_mode, input, 1, 0 = read, 1 = write.
- req_addr, input, BB_ADDR_WIDTH, bridge address.
- req_wdata, input, DATA_WIDTH, write data.
- rsp_valid, output, 1, one-cycle pulse when read data is returned.
- rsp_rdata, output, DATA_WIDTH, read data; holds its value until the next response.
- rsp_timeout, output, 1, one-cycle pulse when a read response times out.
- cmd_done, output, 1, one-cycle pulse when any command completes.
- frame_err, output, 1, one-cycle pulse when a received stop bit is bad.
- busy, output, 1, high whenever not IDLE.
- u_tx, output, 1, UART line to the remote bridge master RX.
- u_rx, input, 1, UART line from the remote bridge master TX.

Function
REQ-007 SHALL form the TX frame F = {req_mode, req_wdata, req_addr}, width W = DATA_WIDTH+BB_ADDR_WIDTH+1 (21 by default), captured on the accept cycle.
REQ-008 SHALL serialize F as: 1 start bit (0), W data bits LSB first (addr[0] first, mode last), then 1 stop bit (1); each bit lasts exactly CLOCKS_PER_PULSE cycles.
REQ-009 SHALL use a command FSM with states IDLE, TX_START, TX_DATA, TX_STOP, WAIT_RSP.
- req_ready = 1 only in IDLE.
- Acceptance occurs when req_valid && req_ready.
REQ-010 SHALL drive u_tx low in the cycle after acceptance (TX_START); u_tx = 1 in IDLE and WAIT_RSP.
REQ-011 SHALL, at the end of TX_STOP, go to IDLE and pulse cmd_done if mode = 1.
- Total write latency from acceptance to cmd_done = (W+2)*CLOCKS_PER_PULSE cycles, ±1.
REQ-012 SHALL, at the end of TX_STOP, go to WAIT_RSP if mode = 0, clear the timeout counter, and arm the receiver.
REQ-013 SHALL use a receiver FSM with states RX_IDLE, RX_START, RX_DATA, RX_STOP.
- Active only while the command FSM is in WAIT_RSP.
- Bytes arriving at any other time are ignored.
REQ-014 SHALL detect start on a u_rx falling edge, using a 2-flop synchronizer on u_rx.
- Confirm start at CLOCKS_PER_PULSE/2; a high line there returns to RX_IDLE.
- Then sample DATA_WIDTH bits LSB first, each CLOCKS_PER_PULSE apart, mid-bit.
REQ-015 SHALL, on a stop bit sampled as 1, do all of the following in the same cycle:
- load rsp_rdata;
- pulse rsp_valid and cmd_done;
- return to IDLE.
REQ-016 SHALL, on a stop bit sampled as 0, pulse frame_err, discard the byte, and remain in WAIT_RSP.
REQ-017 SHALL increment the timeout counter each cycle in WAIT_RSP.
- On reaching RESP_TIMEOUT with no valid byte: pulse rsp_timeout and cmd_done, leave rsp_rdata unchanged, and return to IDLE.
- The receiver returns to RX_IDLE.
REQ-018 SHALL give a valid stop bit priority over timeout when both occur in the same cycle (response wins, no rsp_timeout).
REQ-019 SHALL ignore req_valid and all req_* inputs while busy; no queuing.
REQ-020 SHALL never assert rsp_valid and rsp_timeout together; each completed command produces exactly one cmd_done.

Reset
REQ-021 SHALL, while rst = 1 at a clk edge, return both FSMs to IDLE/RX_IDLE and clear all counters, with outputs as follows:
- u_tx = 1, req_ready = 0 during reset and 1 afterwards, busy = 0.
- rsp_valid = rsp_timeout = cmd_done = frame_err = 0.
- rsp_rdata = 0.
REQ-022 SHALL, on reset mid-frame, release u_tx high on the next cycle and abandon the command with no cmd_done.

Verification (CLOCKS_PER_PULSE = 4, RESP_TIMEOUT = 200)
REQ-023 Write: mode = 1, addr = 0x123, wdata = 0xA5 -> u_tx carries start, then bits of 0x1A5123 LSB first, then stop; cmd_done pulses about 92 cycles after accept; rsp_valid stays 0.
REQ-024 Read: mode = 0, addr = 0x045; after TX, u_rx sends byte 0x3C -> rsp_rdata = 0x3C, rsp_valid and cmd_done pulse together, req_ready returns to 1.
REQ-025 Timeout: read with u_rx held high -> rsp_timeout and cmd_done pulse 200 cycles after entering WAIT_RSP; rsp_rdata keeps its previous value.
REQ-026 Framing: in WAIT_RSP, send 0x55 with stop = 0, then 0x66 valid -> frame_err pulses once, then rsp_rdata = 0x66.
REQ-027 Stray/busy: byte on u_rx during TX -> ignored; req_valid held during TX -> no second accept until IDLE.
REQ-028 Reset mid-TX at bit 10 -> u_tx = 1 next cycle, busy = 0, no cmd_done; the next command transmits correctly.

Source files
------------

// File: rtl/bridge_cmd_issuer.sv
// bridge_cmd_issuer
//   Sends one bridge command at a time over a UART line to a remote bridge
//   master. It then either finishes (write) or waits for a one-byte read
//   response on the return UART line (read).
//
//   Ports
//     clk, rst          : single clock, synchronous active-high reset
//     req_valid/ready   : command handshake (ready only while idle)
//     req_mode          : 0 = read, 1 = write
//     req_addr          : bridge address
//     req_wdata         : write data
//     rsp_valid         : one-cycle pulse, read data returned on rsp_rdata
//     rsp_rdata         : last read data, held until the next response
//     rsp_timeout       : one-cycle pulse, read response never arrived
//     cmd_done          : one-cycle pulse per completed command
//     frame_err         : one-cycle pulse, received byte had a bad stop bit
//     busy              : command in progress
//     u_tx / u_rx       : UART lines to / from the remote bridge master
module bridge_cmd_issuer #(
    parameter int DATA_WIDTH       = 8,
    parameter int BB_ADDR_WIDTH    = 12,
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int RESP_TIMEOUT     = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_mode,
    input  logic [BB_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_timeout,
    output logic                     cmd_done,
    output logic                     frame_err,
    output logic                     busy,
    output logic                     u_tx,
    input  logic                     u_rx
);

    localparam int FRAME_W = DATA_WIDTH + BB_ADDR_WIDTH + 1;
    localparam int BAUD_W  = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int TXB_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int RXB_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TO_W    = $clog2(RESP_TIMEOUT + 1);
    localparam int HALF    = (CLOCKS_PER_PULSE / 2 > 0) ? CLOCKS_PER_PULSE / 2 : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);
    localparam logic [TXB_W-1:0]  TXB_LAST  = TXB_W'(FRAME_W - 1);
    localparam logic [RXB_W-1:0]  RXB_LAST  = RXB_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        WAIT_RSP
    } cmd_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    cmd_state_e                cmd_state_q, cmd_state_d;
    rx_state_e                 rx_state_q, rx_state_d;

    logic [BAUD_W-1:0]         tx_baud_q, tx_baud_d;
    logic [TXB_W-1:0]          tx_bit_q, tx_bit_d;
    logic [FRAME_W-1:0]        frame_q, frame_d;
    logic                      mode_q, mode_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;

    logic                      rx_s1_q, rx_s2_q, rx_prev_q;
    logic [BAUD_W-1:0]         rx_baud_q, rx_baud_d;
    logic [RXB_W-1:0]          rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0]     rx_shift_q, rx_shift_d;

    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic                      cmd_done_q, cmd_done_d;
    logic                      frame_err_q, frame_err_d;

    logic                      tx_tick;
    logic                      rx_tick;
    logic                      rx_fall;
    logic                      rx_stop_ok;
    logic                      rx_stop_bad;
    logic                      timeout_hit;

    assign tx_tick     = (tx_baud_q == BAUD_LAST);
    assign rx_tick     = (rx_baud_q == BAUD_LAST);
    assign rx_fall     = rx_prev_q & ~rx_s2_q;
    assign rx_stop_ok  = (rx_state_q == RX_STOP) && rx_tick && rx_s2_q;
    assign rx_stop_bad = (rx_state_q == RX_STOP) && rx_tick && !rx_s2_q;
    // A good stop bit landing on the last timeout cycle wins over the timeout.
    assign timeout_hit = (cmd_state_q == WAIT_RSP) && (to_cnt_q == TO_LAST) && !rx_stop_ok;

    assign req_ready   = (cmd_state_q == IDLE) && !rst;
    assign busy        = (cmd_state_q != IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign cmd_done    = cmd_done_q;
    assign frame_err   = frame_err_q;
    assign rsp_rdata   = rdata_q;

    always_comb begin
        u_tx = 1'b1;
        if (!rst) begin
            case (cmd_state_q)
                TX_START: u_tx = 1'b0;
                TX_DATA:  u_tx = frame_q[0];
                default:  u_tx = 1'b1;
            endcase
        end
    end

    // Command / transmit FSM
    always_comb begin
        cmd_state_d   = cmd_state_q;
        tx_baud_d     = tx_baud_q;
        tx_bit_d      = tx_bit_q;
        frame_d       = frame_q;
        mode_d        = mode_q;
        to_cnt_d      = to_cnt_q;
        rdata_d       = rdata_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        cmd_done_d    = 1'b0;
        frame_err_d   = 1'b0;

        case (cmd_state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    frame_d     = {req_mode, req_wdata, req_addr};
                    mode_d      = req_mode;
                    tx_baud_d   = '0;
                    cmd_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_baud_d   = '0;
                    tx_bit_d    = '0;
                    cmd_state_d = TX_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_baud_d = '0;
                    frame_d   = frame_q >> 1;
                    if (tx_bit_q == TXB_LAST) begin
                        cmd_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + TXB_W'(1);
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_baud_d = '0;
                    if (mode_q) begin
                        cmd_done_d  = 1'b1;
                        cmd_state_d = IDLE;
                    end else begin
                        to_cnt_d    = '0;
                        cmd_state_d = WAIT_RSP;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            WAIT_RSP: begin
                to_cnt_d    = to_cnt_q + TO_W'(1);
                frame_err_d = rx_stop_bad;
                if (rx_stop_ok) begin
                    rdata_d     = rx_shift_q;
                    rsp_valid_d = 1'b1;
                    cmd_done_d  = 1'b1;
                    cmd_state_d = IDLE;
                end else if (timeout_hit) begin
                    rsp_timeout_d = 1'b1;
                    cmd_done_d    = 1'b1;
                    cmd_state_d   = IDLE;
                end
            end
            default: cmd_state_d = IDLE;
        endcase
    end

    // Receiver FSM; held idle outside WAIT_RSP so stray bytes are dropped.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;

        if ((cmd_state_q != WAIT_RSP) || timeout_hit) begin
            rx_state_d = RX_IDLE;
            rx_baud_d  = '0;
            rx_bit_d   = '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_baud_d  = '0;
                        rx_state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (rx_baud_q == HALF_LAST) begin
                        rx_baud_d = '0;
                        if (!rx_s2_q) begin
                            rx_bit_d   = '0;
                            rx_state_d = RX_DATA;
                        end else begin
                            rx_state_d = RX_IDLE;
                        end
                    end else begin
                        rx_baud_d = rx_baud_q + BAUD_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_baud_d  = '0;
                        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
                        if (rx_bit_q == RXB_LAST) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + RXB_W'(1);
                        end
                    end else begin
                        rx_baud_d = rx_baud_q + BAUD_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_baud_d  = '0;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_baud_d = rx_baud_q + BAUD_W'(1);
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_state_q   <= IDLE;
            rx_state_q    <= RX_IDLE;
            tx_baud_q     <= '0;
            tx_bit_q      <= '0;
            frame_q       <= '0;
            mode_q        <= 1'b0;
            to_cnt_q      <= '0;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_baud_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cmd_done_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            cmd_state_q   <= cmd_state_d;
            rx_state_q    <= rx_state_d;
            tx_baud_q     <= tx_baud_d;
            tx_bit_q      <= tx_bit_d;
            frame_q       <= frame_d;
            mode_q        <= mode_d;
            to_cnt_q      <= to_cnt_d;
            rx_s1_q       <= u_rx;
            rx_s2_q       <= rx_s1_q;
            rx_prev_q     <= rx_s2_q;
            rx_baud_q     <= rx_baud_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rdata_q       <= rdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            cmd_done_q    <= cmd_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_bridge_cmd_issuer.sv
// Testbench for bridge_cmd_issuer with CLOCKS_PER_PULSE = 4, RESP_TIMEOUT = 200.
// Expected TX frames and command completions are queued when a command is
// offered and checked by two monitors when the DUT produces them.
module tb_bridge_cmd_issuer;

    localparam int CPP = 4;
    localparam int TO  = 200;
    localparam int W   = 21;
    localparam int NB  = W + 2;
    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_TO = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         acc;
        int         lmin;
        int         lmax;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        cmd_done;
    logic        frame_err;
    logic        busy;
    logic        u_tx;
    logic        u_rx;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_accept = 0;
    int          n_ferr   = 0;
    bit          tx_abort = 0;
    logic [7:0]  last_rdata = '0;

    logic [W-1:0] tx_q[$];
    exp_t         rsp_q[$];

    bridge_cmd_issuer #(
        .DATA_WIDTH       (8),
        .BB_ADDR_WIDTH    (12),
        .CLOCKS_PER_PULSE (CPP),
        .RESP_TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .cmd_done    (cmd_done),
        .frame_err   (frame_err),
        .busy        (busy),
        .u_tx        (u_tx),
        .u_rx        (u_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) n_accept <= n_accept + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Completion monitor
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (frame_err) n_ferr++;
        if (!rst) begin
            if (cmd_done) begin
                if (rsp_q.size() == 0) begin
                    check("cmd_done_unexpected", cmd_done, 0);
                end else begin
                    e   = rsp_q.pop_front();
                    lat = cyc - e.acc;
                    check("rsp_valid_at_done", rsp_valid, (e.kind == K_RD));
                    check("rsp_timeout_at_done", rsp_timeout, (e.kind == K_TO));
                    if (e.kind != K_WR) check("rsp_rdata", rsp_rdata, e.data);
                    check("done_latency_in_range", (lat >= e.lmin && lat <= e.lmax), 1);
                end
            end else if (rsp_valid || rsp_timeout) begin
                check("rsp_pulse_without_done", cmd_done, 1);
            end
        end
    end

    // TX frame monitor: samples each bit one cycle into its 4-cycle slot
    initial begin : tx_mon
        logic          prev;
        logic [NB-1:0] bits;
        bit            aborted;
        logic [W-1:0]  e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !u_tx) begin
                aborted = 0;
                bits    = '0;
                for (int k = 0; k <= CPP*(NB-1)+1; k++) begin
                    if (rst || tx_abort) aborted = 1;
                    if (k % CPP == 1) bits[k/CPP] = u_tx;
                    if (k != CPP*(NB-1)+1) @(negedge clk);
                end
                if (tx_q.size() == 0) begin
                    check("tx_frame_unexpected", bits[W:1], 0);
                end else begin
                    e = tx_q.pop_front();
                    if (!aborted) begin
                        check("tx_start_bit", bits[0], 0);
                        check("tx_frame_bits", bits[W:1], e);
                        check("tx_stop_bit", bits[NB-1], 1);
                    end
                end
                tx_abort = 0;
            end
            prev = u_tx;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; offers one command and queues its expectations.
    task automatic send_cmd(input logic mode, input logic [11:0] addr, input logic [7:0] wd,
                            input bit hold, input int kind, input logic [7:0] rd);
        int   t;
        exp_t e;
        t = 0;
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_before_cmd", req_ready, 1);
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        e.kind = kind;
        e.acc  = cyc + 1;
        if (kind == K_WR) begin
            e.data = '0; e.lmin = (W+2)*CPP - 1; e.lmax = (W+2)*CPP + 1;
        end else if (kind == K_RD) begin
            e.data = rd; e.lmin = (W+2)*CPP + 1; e.lmax = (W+2)*CPP + TO;
            last_rdata = rd;
        end else begin
            e.data = last_rdata; e.lmin = (W+2)*CPP + TO - 1; e.lmax = (W+2)*CPP + TO + 1;
        end
        tx_q.push_back({mode, wd, addr});
        rsp_q.push_back(e);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        u_rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        u_rx = stop;
        repeat (CPP) @(negedge clk);
        u_rx = 1'b1;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        repeat (2) @(negedge clk);
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("busy_cleared", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n0;
        int f0;
        rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0;
        req_addr = '0; req_wdata = '0; u_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_u_tx", u_tx, 1);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        // Write 0x123 <= 0xA5: frame 0x1A5123, done ~92 cycles later
        send_cmd(1'b1, 12'h123, 8'hA5, 0, K_WR, 8'h00);
        check("busy_during_write", busy, 1);
        check("req_ready_during_write", req_ready, 0);
        wait_idle();

        // Read 0x045 answered with 0x3C
        send_cmd(1'b0, 12'h045, 8'h5E, 0, K_RD, 8'h3C);
        repeat (95) @(negedge clk);
        uart_send(8'h3C, 1'b1);
        wait_idle();
        check("req_ready_after_read", req_ready, 1);
        check("rdata_after_read", rsp_rdata, 8'h3C);

        // Read with no answer: timeout, rdata keeps 0x3C
        send_cmd(1'b0, 12'h0A7, 8'h00, 0, K_TO, 8'h00);
        wait_idle();
        check("rdata_after_timeout", rsp_rdata, 8'h3C);

        // Bad stop bit on 0x55, then good 0x66
        send_cmd(1'b0, 12'hF0F, 8'h11, 0, K_RD, 8'h66);
        repeat (95) @(negedge clk);
        f0 = n_ferr;
        uart_send(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        check("frame_err_pulses_after_bad_byte", n_ferr - f0, 1);
        check("busy_after_bad_byte", busy, 1);
        uart_send(8'h66, 1'b1);
        wait_idle();
        check("frame_err_pulses_total_framing", n_ferr - f0, 1);
        check("rdata_after_framing", rsp_rdata, 8'h66);

        // Stray byte during TX and req_valid held with changing fields
        n0 = n_accept;
        send_cmd(1'b1, 12'h7E1, 8'h3D, 1, K_WR, 8'h00);
        req_mode = 1'b0; req_addr = 12'hFFF; req_wdata = 8'h00;
        fork
            begin
                repeat (10) @(negedge clk);
                uart_send(8'h99, 1'b1);
            end
            begin
                repeat (78) @(negedge clk);
                check("accepts_while_busy", n_accept - n0, 1);
                req_valid = 1'b0;
            end
        join
        wait_idle();
        check("rdata_after_stray", rsp_rdata, 8'h66);

        // Reset while bit 10 of a write is on the line
        send_cmd(1'b1, 12'h2B4, 8'hC7, 0, K_WR, 8'h00);
        repeat (44) @(negedge clk);
        rsp_q.delete();
        tx_abort = 1;
        rst = 1'b1;
        @(negedge clk);
        check("midtx_rst_u_tx", u_tx, 1);
        check("midtx_rst_busy", busy, 0);
        check("midtx_rst_req_ready", req_ready, 0);
        check("midtx_rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        check("midtx_post_rst_u_tx", u_tx, 1);
        repeat (100) @(negedge clk);

        // Commands after reset
        send_cmd(1'b1, 12'h5A6, 8'h3E, 0, K_WR, 8'h00);
        wait_idle();
        send_cmd(1'b0, 12'h301, 8'h00, 0, K_RD, 8'h81);
        repeat (95) @(negedge clk);
        uart_send(8'h81, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("frame_err_grand_total", n_ferr, 1);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
